// File: rtl/hot_water_arbiter.sv
// rtl/hot_water_arbiter.sv - round-robin hot-water supply arbiter with heater reheat interval
// Define HOT_ARB_TIMEOUT_EN to cut grants at MAX_GRANT cycles and pulse timeout.
module hot_water_arbiter #(
  parameter int N         = 4,
  parameter int MAX_GRANT = 64,
  parameter int REHEAT    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 power,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         done,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 grant_valid,
  output logic                 heater_on,
  output logic                 timeout
);
  localparam int IDW = $clog2(N);
  localparam int RW  = $clog2(REHEAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_REHEAT} state_t;

  state_t           state_q;
  logic [N-1:0]     grant_q;
  logic [IDW-1:0]   grant_id_q;
  logic [IDW-1:0]   ptr_q;
  logic             grant_valid_q;
  logic             heater_on_q;
  logic [RW-1:0]    rh_cnt_q;

  logic             found_d;
  logic [IDW-1:0]   sel_d;
  logic [IDW-1:0]   idx_d;
  logic             release_d;
  logic             cut_d;

`ifdef HOT_ARB_TIMEOUT_EN
  localparam int GW = $clog2(MAX_GRANT);
  logic [GW-1:0]    g_cnt_q;
  logic             timeout_q;

  assign cut_d   = (g_cnt_q == GW'(MAX_GRANT - 1));
  assign timeout = timeout_q;
`else
  assign cut_d   = 1'b0;
  assign timeout = 1'b0;
`endif

  // First requester after the previous winner, wrapping modulo N.
  always_comb begin
    found_d = 1'b0;
    sel_d   = '0;
    idx_d   = '0;
    for (int i = 1; i <= N; i++) begin
      idx_d = IDW'((int'(ptr_q) + i) % N);
      if (!found_d && req[idx_d]) begin
        found_d = 1'b1;
        sel_d   = idx_d;
      end
    end
  end

  assign release_d = done[grant_id_q] | ~req[grant_id_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      grant_id_q    <= '0;
      ptr_q         <= IDW'(N - 1);
      grant_valid_q <= 1'b0;
      heater_on_q   <= 1'b0;
      rh_cnt_q      <= '0;
`ifdef HOT_ARB_TIMEOUT_EN
      g_cnt_q       <= '0;
      timeout_q     <= 1'b0;
`endif
    end else if (!power) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      heater_on_q   <= 1'b0;
      rh_cnt_q      <= '0;
`ifdef HOT_ARB_TIMEOUT_EN
      g_cnt_q       <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
`ifdef HOT_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (found_d) begin
            state_q       <= S_GRANT;
            grant_q       <= N'(1) << sel_d;
            grant_id_q    <= sel_d;
            ptr_q         <= sel_d;
            grant_valid_q <= 1'b1;
            heater_on_q   <= 1'b1;
`ifdef HOT_ARB_TIMEOUT_EN
            g_cnt_q       <= '0;
`endif
          end
        end
        S_GRANT: begin
          // A release on the cut edge wins, so no timeout pulse then.
          if (release_d || cut_d) begin
            state_q       <= S_REHEAT;
            grant_q       <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            rh_cnt_q      <= '0;
`ifdef HOT_ARB_TIMEOUT_EN
            timeout_q     <= ~release_d;
            g_cnt_q       <= '0;
          end else begin
            g_cnt_q       <= g_cnt_q + 1'b1;
`endif
          end
        end
        S_REHEAT: begin
          if (rh_cnt_q == RW'(REHEAT - 1)) begin
            state_q     <= S_IDLE;
            heater_on_q <= 1'b0;
            rh_cnt_q    <= '0;
          end else begin
            rh_cnt_q    <= rh_cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign grant_valid = grant_valid_q;
  assign heater_on   = heater_on_q;

endmodule

// File: tb/tb_hot_water_arbiter.sv
// tb/tb_hot_water_arbiter.sv - directed and random checks of hot_water_arbiter against a cycle model
module tb_hot_water_arbiter;
  localparam int N         = 4;
  localparam int MAX_GRANT = 64;
  localparam int REHEAT    = 8;
  localparam int IDW       = $clog2(N);
`ifdef HOT_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           power;
  logic [N-1:0]   req;
  logic [N-1:0]   done;
  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_id;
  logic           grant_valid;
  logic           heater_on;
  logic           timeout;

  int checks   = 0;
  int failures = 0;

  // Model state: current holder (-1 none), cycles held, reheat cycles left, last winner.
  int m_cur;
  int m_len;
  int m_rh;
  int m_ptr;
  bit m_tmo;

  hot_water_arbiter #(.N(N), .MAX_GRANT(MAX_GRANT), .REHEAT(REHEAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .power      (power),
    .req        (req),
    .done       (done),
    .grant      (grant),
    .grant_id   (grant_id),
    .grant_valid(grant_valid),
    .heater_on  (heater_on),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_cur = -1;
    m_len = 0;
    m_rh  = 0;
    m_ptr = N - 1;
    m_tmo = 1'b0;
  endfunction

  function automatic void model_edge();
    logic [IDW-1:0] ix;
    bit             hit;
    m_tmo = 1'b0;
    if (!power) begin
      m_cur = -1;
      m_len = 0;
      m_rh  = 0;
    end else if (m_cur >= 0) begin
      m_len++;
      if (done[IDW'(m_cur)] || !req[IDW'(m_cur)]) begin
        m_cur = -1;
        m_rh  = REHEAT;
      end else if (TMO_EN && m_len >= MAX_GRANT) begin
        m_cur = -1;
        m_rh  = REHEAT;
        m_tmo = 1'b1;
      end
    end else if (m_rh > 0) begin
      m_rh--;
    end else if (req != '0) begin
      hit = 1'b0;
      for (int k = 1; k <= N; k++) begin
        ix = IDW'((m_ptr + k) % N);
        if (!hit && req[ix]) begin
          hit   = 1'b1;
          m_cur = int'(ix);
        end
      end
      m_ptr = m_cur;
      m_len = 0;
    end
  endfunction

  task automatic check_model(input string ph);
    logic [N-1:0] eg;
    eg = '0;
    if (m_cur >= 0) eg[IDW'(m_cur)] = 1'b1;
    chk({ph, "/grant"},       32'(grant),       32'(eg));
    chk({ph, "/grant_id"},    32'(grant_id),    (m_cur >= 0) ? m_cur : 0);
    chk({ph, "/grant_valid"}, 32'(grant_valid), 32'(m_cur >= 0));
    chk({ph, "/heater_on"},   32'(heater_on),   32'(m_cur >= 0 || m_rh > 0));
    chk({ph, "/timeout"},     32'(timeout),     32'(m_tmo));
  endtask

  task automatic step(input string ph);
    @(posedge clk);
    model_edge();
    #1;
    check_model(ph);
  endtask

  initial begin
    int n;
    bit found;
    bit counting;
    int exp_order [5] = '{0, 1, 2, 3, 0};

    rst   = 1'b1;
    power = 1'b0;
    req   = '0;
    done  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    rst   = 1'b0;
    power = 1'b1;
    step("idle");

    // First grant one cycle after the request, lowest index after ptr=N-1.
    req = 4'b0101;
    step("t1");
    chk("t1_grant",    32'(grant),     32'(4'b0001));
    chk("t1_grant_id", 32'(grant_id),  0);
    chk("t1_heater",   32'(heater_on), 1);

    // Release, then REHEAT+1 empty cycles before the next requester wins.
    done = 4'b0001;
    step("t2_rel");
    done = '0;
    n = (grant == '0) ? 1 : 0;
    counting = 1'b1;
    for (int w = 0; w < 20 && counting; w++) begin
      step("t2_gap");
      if (grant == '0) n++;
      else counting = 1'b0;
    end
    chk("t2_gap_len", n, REHEAT + 1);
    chk("t2_grant",   32'(grant), 32'(4'b0100));
    req = '0;
    repeat (12) step("t2_drain");

    // Single requester held with no release.
    req = 4'b0010;
    step("t3_start");
    chk("t3_grant", 32'(grant), 32'(4'b0010));
`ifdef HOT_ARB_TIMEOUT_EN
    n = 1;
    counting = 1'b1;
    for (int w = 0; w < 100 && counting; w++) begin
      step("t3_hold");
      if (grant == 4'b0010) n++;
      else counting = 1'b0;
    end
    chk("t3_len",        n,                MAX_GRANT);
    chk("t3_timeout",    32'(timeout),     1);
    chk("t3_heater",     32'(heater_on),   1);
    step("t3_rh");
    chk("t3_tmo_pulse",  32'(timeout),     0);
    repeat (REHEAT - 1) step("t3_rh");
    chk("t3_idle_heat",  32'(heater_on),   0);
    chk("t3_idle_grant", 32'(grant),       0);
    step("t3_regrant");
    chk("t3_regrant",    32'(grant),       32'(4'b0010));
`else
    repeat (100) step("t3_hold");
    chk("t3_held",       32'(grant),       32'(4'b0010));
    chk("t3_no_timeout", 32'(timeout),     0);
`endif
    req = '0;
    repeat (12) step("t3_drain");

    // Restore ptr=N-1, then all four contend with 3-cycle grants.
    #2 rst = 1'b1;
    model_reset();
    #2 rst = 1'b0;
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      found = 1'b0;
      for (int w = 0; w < 20 && !found; w++) begin
        step("t4_wait");
        if (grant_valid) found = 1'b1;
      end
      chk("t4_found", 32'(found),    1);
      chk("t4_order", 32'(grant_id), exp_order[g]);
      step("t4_hold");
      step("t4_hold");
      done = 4'b1111;
      step("t4_rel");
      done = '0;
    end

    // Power loss mid-grant, then restore: next in rotation wins.
    found = 1'b0;
    for (int w = 0; w < 20 && !found; w++) begin
      step("t5_wait");
      if (grant_valid) found = 1'b1;
    end
    chk("t5_first", 32'(grant_id), 1);
    step("t5_hold");
    power = 1'b0;
    step("t5_off");
    chk("t5_off_grant",   32'(grant),       0);
    chk("t5_off_valid",   32'(grant_valid), 0);
    chk("t5_off_heater",  32'(heater_on),   0);
    chk("t5_off_timeout", 32'(timeout),     0);
    power = 1'b1;
    step("t5_on");
    chk("t5_regrant", 32'(grant), 32'(4'b0100));

    // Asynchronous reset during REHEAT.
    req = '0;
    repeat (3) step("t6_rh");
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("t6_rst_grant",  32'(grant),       0);
    chk("t6_rst_valid",  32'(grant_valid), 0);
    chk("t6_rst_heater", 32'(heater_on),   0);
    chk("t6_rst_id",     32'(grant_id),    0);
    chk("t6_rst_tmo",    32'(timeout),     0);
    #1 rst = 1'b0;
    req = 4'b1000;
    step("t6_grant");
    chk("t6_grant", 32'(grant), 32'(4'b1000));
    req = '0;
    repeat (12) step("t6_drain");

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(39) == 0) req = N'($urandom);
      done  = ($urandom_range(79) == 0) ? N'($urandom) : '0;
      power = ($urandom_range(299) != 0);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
